// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the instruction cache.
//   icache_state_t : refill FSM states (READY, REQ, FILL)
//   ICACHE_LINES   : default number of cache lines
//   ICACHE_WORDS   : default 32-bit words per line
package mips_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2
  } icache_state_t;

  localparam int ICACHE_LINES = 16;
  localparam int ICACHE_WORDS = 4;

endpackage

// File: rtl/icache_store.sv
// Storage arrays for the direct-mapped instruction cache.
// Ports:
//   clk, reset          : clock, async active-low reset (clears valids only)
//   rd_idx/rd_off       : combinational read address (line, word)
//   rd_valid/rd_tag/rd_word : read results for the addressed line/word
//   inv_all             : clear every valid bit at the edge (wins over tag_we)
//   word_we/wr_idx/wr_off/wr_word : synchronous single-word write
//   tag_we/wr_tag/wr_valid        : synchronous tag + valid write for wr_idx
module icache_store
  import mips_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WORDS = ICACHE_WORDS,
  localparam int OW = $clog2(WORDS),
  localparam int IW = $clog2(LINES),
  localparam int TW = 32 - OW - IW - 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx,
  input  logic [OW-1:0] rd_off,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_word,
  input  logic          inv_all,
  input  logic          word_we,
  input  logic [IW-1:0] wr_idx,
  input  logic [OW-1:0] wr_off,
  input  logic [31:0]   wr_word,
  input  logic          tag_we,
  input  logic [TW-1:0] wr_tag,
  input  logic          wr_valid
);

  logic [LINES-1:0]           valid;
  logic [TW-1:0]              tags [LINES];
  logic [WORDS-1:0][31:0]     data [LINES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       valid <= '0;
    else if (inv_all) valid <= '0;
    else if (tag_we)  valid[wr_idx] <= wr_valid;
  end

  // Data and tags carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (word_we) data[wr_idx][wr_off] <= wr_word;
    if (tag_we)  tags[wr_idx]         <= wr_tag;
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_word  = data[rd_idx][rd_off];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache on the fetch path.
// Hits return InstrF combinationally from PCF; a miss stalls the pipeline
// while one line is burst-refilled from main memory.
// Ports:
//   clk, reset            : clock, async active-low reset
//   PCF, InstrF           : fetch address in, instruction out (0 while stalled)
//   ICacheStall           : miss in progress, freeze PCF and F/D
//   InvAll                : one-cycle pulse, invalidate every line
//   MemReq, MemAddr, MemGnt        : line request handshake
//   MemValid, MemRData             : refill beats, ascending word order
module icache_fetch
  import mips_pkg::*;
#(
  parameter int LINES = ICACHE_LINES,
  parameter int WORDS = ICACHE_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        ICacheStall,
  input  logic        InvAll,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemGnt,
  input  logic        MemValid,
  input  logic [31:0] MemRData
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - OW - IW - 2;

  icache_state_t state;
  logic [OW-1:0] beat;
  logic          discard;

  logic [OW-1:0] pc_off;
  logic [IW-1:0] pc_idx;
  logic [TW-1:0] pc_tag;
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_word;
  logic          hit, rdy_hit, fill_beat, last_beat;
  logic          unused;

  assign pc_off = PCF[OW+1:2];
  assign pc_idx = PCF[OW+IW+1:OW+2];
  assign pc_tag = PCF[31:OW+IW+2];
  assign unused = ^PCF[1:0];

  assign hit       = rd_valid && (rd_tag == pc_tag);
  assign rdy_hit   = (state == READY) && hit;
  assign fill_beat = (state == FILL) && MemValid;
  assign last_beat = fill_beat && (beat == OW'(WORDS-1));

  assign InstrF      = rdy_hit ? rd_word : 32'h0;
  assign ICacheStall = !rdy_hit;

  // MemAddr doubles as the miss latch: its index/tag fields steer the fill.
  icache_store #(.LINES(LINES), .WORDS(WORDS)) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pc_idx),
    .rd_off   (pc_off),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_word  (rd_word),
    .inv_all  (InvAll),
    .word_we  (fill_beat),
    .wr_idx   (MemAddr[OW+IW+1:OW+2]),
    .wr_off   (beat),
    .wr_word  (MemRData),
    .tag_we   (last_beat),
    .wr_tag   (MemAddr[31:OW+IW+2]),
    .wr_valid (!discard)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= READY;
      beat    <= '0;
      discard <= 1'b0;
      MemReq  <= 1'b0;
      MemAddr <= '0;
    end else begin
      case (state)
        READY: if (!hit) begin
          MemAddr <= {PCF[31:OW+2], {(OW+2){1'b0}}};
          MemReq  <= 1'b1;
          beat    <= '0;
          state   <= REQ;
        end
        REQ: if (MemGnt) begin
          MemReq <= 1'b0;
          state  <= FILL;
        end
        FILL: if (MemValid) begin
          if (beat == OW'(WORDS-1)) state <= READY;
          else                      beat  <= beat + OW'(1);
        end
        default: state <= READY;
      endcase
      // An invalidate racing an outstanding fill must keep that line invalid;
      // the flag is consumed by the final beat (InvAll on that beat is
      // already covered by the store clearing valids).
      if (last_beat)                     discard <= 1'b0;
      else if (InvAll && state != READY) discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed, table-driven bench for icache_fetch: one row per clock cycle
// holding the inputs for that cycle and the outputs expected in it.
module tb_icache_fetch;

  logic        clk, reset;
  logic [31:0] PCF, InstrF, MemAddr, MemRData;
  logic        ICacheStall, InvAll, MemReq, MemGnt, MemValid;

  int tests = 0;
  int fails = 0;

  icache_fetch #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .InstrF(InstrF),
    .ICacheStall(ICacheStall), .InvAll(InvAll), .MemReq(MemReq),
    .MemAddr(MemAddr), .MemGnt(MemGnt), .MemValid(MemValid),
    .MemRData(MemRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic        inv, gnt, mv;
    logic [31:0] rd;
    logic        stall;
    logic [31:0] instr;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vq[$];

  task automatic v(input logic [31:0] pcf, input logic inv, gnt, mv,
                   input logic [31:0] rd, input logic stall,
                   input logic [31:0] instr, input logic req,
                   input logic [31:0] addr);
    vec_t e;
    e.pcf = pcf; e.inv = inv; e.gnt = gnt; e.mv = mv; e.rd = rd;
    e.stall = stall; e.instr = instr; e.req = req; e.addr = addr;
    vq.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] got, exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    // miss on 0x0, immediate grant, back-to-back beats
    v(32'h0,   0,1,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h0,   0,1,0,32'h0,        1,32'h0,        1,32'h0);
    v(32'h0,   0,0,1,32'h20080005, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,1,32'h20090007, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,1,32'h01095020, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,1,32'hAC0A0000, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,0,32'h0,        0,32'h20080005, 0,32'h0);
    v(32'h4,   0,0,0,32'h0,        0,32'h20090007, 0,32'h0);
    v(32'h8,   0,0,0,32'h0,        0,32'h01095020, 0,32'h0);
    v(32'hC,   0,0,0,32'h0,        0,32'hAC0A0000, 0,32'h0);
    // conflict: 0x100 shares index 0 with a different tag
    v(32'h100, 0,1,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h100, 0,1,0,32'h0,        1,32'h0,        1,32'h100);
    v(32'h100, 0,0,1,32'h11111111, 1,32'h0,        0,32'h0);
    v(32'h100, 0,0,1,32'h22222222, 1,32'h0,        0,32'h0);
    v(32'h100, 0,0,1,32'h33333333, 1,32'h0,        0,32'h0);
    v(32'h100, 0,0,1,32'h44444444, 1,32'h0,        0,32'h0);
    v(32'h100, 0,0,0,32'h0,        0,32'h11111111, 0,32'h0);
    // 0x0 evicted; grant delayed 3 cycles, 3 gap cycles in the burst
    v(32'h0,   0,0,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h0,   0,0,0,32'h0,        1,32'h0,        1,32'h0);
    v(32'h8,   0,0,0,32'h0,        1,32'h0,        1,32'h0);
    v(32'h0,   0,0,1,32'hDEADBEEF, 1,32'h0,        1,32'h0);
    v(32'h0,   0,1,0,32'h0,        1,32'h0,        1,32'h0);
    v(32'h0,   0,0,1,32'hA0000000, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h104, 0,0,1,32'hA1000000, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h0,   0,0,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h0,   0,0,1,32'hA2000000, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,1,32'hA3000000, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,0,32'h0,        0,32'hA0000000, 0,32'h0);
    v(32'hC,   0,0,0,32'h0,        0,32'hA3000000, 0,32'h0);
    // InvAll mid-fill on line 4: fill completes but line stays invalid
    v(32'h40,  0,1,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h40,  0,1,0,32'h0,        1,32'h0,        1,32'h40);
    v(32'h40,  0,0,1,32'hB0000000, 1,32'h0,        0,32'h0);
    v(32'h40,  1,0,1,32'hB1000000, 1,32'h0,        0,32'h0);
    v(32'h40,  0,0,1,32'hB2000000, 1,32'h0,        0,32'h0);
    v(32'h40,  0,0,1,32'hB3000000, 1,32'h0,        0,32'h0);
    v(32'h40,  0,0,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h40,  0,1,0,32'h0,        1,32'h0,        1,32'h40);
    v(32'h40,  0,0,1,32'hC0000000, 1,32'h0,        0,32'h0);
    v(32'h40,  0,0,1,32'hC1000000, 1,32'h0,        0,32'h0);
    v(32'h40,  0,0,1,32'hC2000000, 1,32'h0,        0,32'h0);
    v(32'h40,  0,0,1,32'hC3000000, 1,32'h0,        0,32'h0);
    v(32'h40,  0,0,0,32'h0,        0,32'hC0000000, 0,32'h0);
    // line 0 was cleared by that InvAll too; start a fill to cut by reset
    v(32'h0,   0,1,0,32'h0,        1,32'h0,        0,32'h0);
    v(32'h0,   0,1,0,32'h0,        1,32'h0,        1,32'h0);
    v(32'h0,   0,0,1,32'hD0000000, 1,32'h0,        0,32'h0);
    v(32'h0,   0,0,1,32'hD1000000, 1,32'h0,        0,32'h0);

    reset = 1'b0; PCF = 32'h0; InvAll = 0; MemGnt = 0; MemValid = 0;
    MemRData = 32'h0;
    @(posedge clk); #1;
    #4;
    check("rst_stall", {31'h0, ICacheStall}, 32'h1);
    check("rst_req",   {31'h0, MemReq},      32'h0);
    check("rst_addr",  MemAddr,              32'h0);
    check("rst_instr", InstrF,               32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      PCF = vq[i].pcf; InvAll = vq[i].inv; MemGnt = vq[i].gnt;
      MemValid = vq[i].mv; MemRData = vq[i].rd;
      #4;
      tests++;
      if (ICacheStall !== vq[i].stall || InstrF !== vq[i].instr ||
          MemReq !== vq[i].req || (vq[i].req && MemAddr !== vq[i].addr)) begin
        fails++;
        $display("FAIL vec%0d: got stall=%b instr=%h req=%b addr=%h expected stall=%b instr=%h req=%b addr=%h",
                 i, ICacheStall, InstrF, MemReq, MemAddr,
                 vq[i].stall, vq[i].instr, vq[i].req, vq[i].addr);
      end
      @(posedge clk); #1;
    end

    // beat 2 of the fill: reset asserted asynchronously mid-cycle
    InvAll = 0; MemGnt = 0; MemValid = 1; MemRData = 32'hD2000000;
    #2 reset = 1'b0;
    #1;
    check("rstfill_req",   {31'h0, MemReq},      32'h0);
    check("rstfill_stall", {31'h0, ICacheStall}, 32'h1);
    check("rstfill_addr",  MemAddr,              32'h0);
    MemValid = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    #4;
    check("post_rst_stall", {31'h0, ICacheStall}, 32'h1);
    check("post_rst_instr", InstrF,               32'h0);
    @(posedge clk); #1;
    #2;
    check("post_rst_req",  {31'h0, MemReq}, 32'h1);
    check("post_rst_addr", MemAddr,         32'h0);
    // reset while the request is pending must drop MemReq at once
    reset = 1'b0;
    #1;
    check("rstreq_req", {31'h0, MemReq}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    #4;
    check("rstreq_stall", {31'h0, ICacheStall}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
